// File: rtl/load_store_unit.sv
// load_store_unit: LB/LW/SB/SW stage between the ALU and a req/gnt/rvalid
// data-memory port. Returns a sign-extended load result with a one-cycle
// done pulse to the control FSM.
// Optional build macro: LSU_MISALIGN_CHECK_EN (reject misaligned word access).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_i; operands captured on acceptance
// REQ    | mem_req_o high, request fields held until mem_gnt_i
// WAIT   | load granted, waiting for mem_rvalid_i
// DONE   | done_o (and err_o / misalign_o) pulse for one cycle
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH/8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                  we_q;
    logic                  byte_q;
    logic                  err_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  f3_byte;
    logic                  f3_word;
    logic                  f3_bad;
    logic                  misaligned;
    logic                  accept;
    logic [7:0]            lane_byte;
    logic [DATA_WIDTH-1:0] load_val;

    assign f3_byte = (funct3_i == 3'b000);
    assign f3_word = (funct3_i == 3'b010);
    assign f3_bad  = !(f3_byte || f3_word);
    assign accept  = (state_q == S_IDLE) && start_i;

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_q;

    assign misaligned = f3_word && (addr_i[1:0] != 2'b00);
    assign misalign_o = (state_q == S_DONE) && mis_q;

    // Misalign flag is captured with the operands and reported in DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= misaligned && !f3_bad;
        end
    end
`else
    // Word accesses silently drop addr[1:0]; no misalignment is reported.
    assign misaligned = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rejected accesses skip the memory port entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (f3_bad || misaligned) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture: memory-side address, lanes and write image are
    // formed once at acceptance so they stay stable through REQ.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= we_i;
            byte_q  <= f3_byte;
            err_q   <= f3_bad;
            off_q   <= addr_i[1:0];
            addr_q  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
            if (f3_byte) begin
                be_q    <= BE_WIDTH'(1) << addr_i[1:0];
                wdata_q <= {BE_WIDTH{wdata_i[7:0]}};
            end else begin
                be_q    <= '1;
                wdata_q <= wdata_i;
            end
        end
    end

    assign lane_byte = mem_rdata_i[{off_q, 3'b000} +: 8];
    assign load_val  = byte_q ? {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte}
                              : mem_rdata_i;

    // Load result is only written by a read response in WAIT, so stores,
    // rejected accesses and stale responses leave it untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if ((state_q == S_WAIT) && mem_rvalid_i) begin
            rdata_q <= load_val;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = done_o && err_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = (state_q == S_REQ);
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule
